// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout <= 1) return 1;
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of mem_bus_arbiter; master = arbiter, slave = environment.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              p0_ack, p1_ack;
  logic              p0_err, p1_err;
  logic [31:0]       mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [31:0]       mem_write_val;
  logic [31:0]       mem_read_val;
  logic              mem_response;
  logic              busy;
  logic              grant_id;

  modport master (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
           mem_read_val, mem_response,
    output p0_rdata, p1_rdata, p0_ack, p1_ack, p0_err, p1_err,
           mem_addr, mem_read_en, mem_write_en, mem_write_val, busy, grant_id
  );

  modport slave (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
           mem_read_val, mem_response,
    input  p0_rdata, p1_rdata, p0_ack, p1_ack, p0_err, p1_err,
           mem_addr, mem_read_en, mem_write_en, mem_write_val, busy, grant_id
  );
endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner select between the two requesters.
// Round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority to port 1.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       win_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    valid_o = |req_i;
    win_o   = PORT_IFETCH;
    if (&req_i)        win_o = ~last_i;
    else if (req_i[1]) win_o = PORT_DATA;
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    valid_o = |req_i;
    win_o   = req_i[1] ? PORT_DATA : PORT_IFETCH;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter onto a single 4-phase memory bus with response timeout.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_picker).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  localparam int unsigned    CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic              pick_valid, pick_win;

  // The grant register doubles as the round-robin pointer: both update on every grant.
  mem_arb_picker u_picker (
    .req_i   ({bus.p1_req, bus.p0_req}),
    .last_i  (gnt_q),
    .valid_o (pick_valid),
    .win_o   (pick_win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          gnt_d   = pick_win;
          if (pick_win == PORT_DATA) begin
            addr_d  = bus.p1_addr;
            we_d    = bus.p1_we;
            wdata_d = bus.p1_wdata;
          end else begin
            addr_d  = bus.p0_addr;
            we_d    = bus.p0_we;
            wdata_d = bus.p0_wdata;
          end
          rd_en_d = ~we_d;
          wr_en_d = we_d;
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_response) begin
          state_d = ST_RELEASE;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (gnt_q == PORT_DATA) begin
            ack1_d = 1'b1;
            if (!we_q) rdata1_d = bus.mem_read_val[DATA_W-1:0];
          end else begin
            ack0_d = 1'b1;
            if (!we_q) rdata0_d = bus.mem_read_val[DATA_W-1:0];
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ST_RELEASE;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          if (gnt_q == PORT_DATA) begin
            ack1_d = 1'b1;
            err1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
            err0_d = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (!bus.mem_response) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign bus.mem_addr      = 32'(addr_q);
  assign bus.mem_write_val = 32'(wdata_q);
  assign bus.mem_read_en   = rd_en_q;
  assign bus.mem_write_en  = wr_en_q;
  assign bus.p0_rdata      = rdata0_q;
  assign bus.p1_rdata      = rdata1_q;
  assign bus.p0_ack        = ack0_q;
  assign bus.p1_ack        = ack1_q;
  assign bus.p0_err        = err0_q;
  assign bus.p1_err        = err1_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.grant_id      = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT overridden to 8).
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_p0_rdata;
  logic [31:0] exp_p1_rdata;
  logic        exp_gnt [3];

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_gnt[0] = 1'b1; exp_gnt[1] = 1'b0; exp_gnt[2] = 1'b1;
`else
    exp_gnt[0] = 1'b1; exp_gnt[1] = 1'b1; exp_gnt[2] = 1'b1;
`endif
    bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
    bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_wdata = '0; bus.p1_wdata = '0;
    bus.mem_read_val = '0; bus.mem_response = 0;

    // Reset state
    tick(); tick();
    chk("rst_rd_en", 32'(bus.mem_read_en), 0);
    chk("rst_wr_en", 32'(bus.mem_write_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", {30'd0, bus.p1_ack, bus.p0_ack}, 0);
    chk("rst_gnt", 32'(bus.grant_id), 0);
    chk("rst_addr", bus.mem_addr, 0);
    reset = 0;

    // 1. Single read on port 0
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10;
    tick();
    chk("rd_en_rise", 32'(bus.mem_read_en), 1);
    chk("rd_wr_en", 32'(bus.mem_write_en), 0);
    chk("rd_addr", bus.mem_addr, 32'h10);
    chk("rd_busy", 32'(bus.busy), 1);
    chk("rd_gnt", 32'(bus.grant_id), 0);
    tick(); tick();
    chk("rd_wait_ack", 32'(bus.p0_ack), 0);
    bus.mem_response = 1; bus.mem_read_val = 32'hDEADBEEF;
    tick();
    chk("rd_ack", 32'(bus.p0_ack), 1);
    chk("rd_err", 32'(bus.p0_err), 0);
    chk("rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("rd_en_drop", 32'(bus.mem_read_en), 0);
    chk("rd_p1_ack", 32'(bus.p1_ack), 0);
    bus.p0_req = 0; bus.mem_response = 0;
    tick();
    chk("rd_ack_pulse", 32'(bus.p0_ack), 0);
    chk("rd_idle", 32'(bus.busy), 0);
    chk("rd_hold", bus.p0_rdata, 32'hDEADBEEF);

    // 2. Single write on port 1
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h40; bus.p1_wdata = 32'h12345678;
    tick();
    chk("wr_en", 32'(bus.mem_write_en), 1);
    chk("wr_rd_en", 32'(bus.mem_read_en), 0);
    chk("wr_addr", bus.mem_addr, 32'h40);
    chk("wr_val", bus.mem_write_val, 32'h12345678);
    chk("wr_gnt", 32'(bus.grant_id), 1);
    tick();
    chk("wr_en_hold", 32'(bus.mem_write_en), 1);
    bus.mem_response = 1; bus.mem_read_val = 32'hCAFEF00D;
    tick();
    chk("wr_ack", 32'(bus.p1_ack), 1);
    chk("wr_en_drop", 32'(bus.mem_write_en), 0);
    chk("wr_no_rdata", bus.p1_rdata, 0);
    bus.p1_req = 0; bus.mem_response = 0;
    tick();
    chk("wr_ack_pulse", 32'(bus.p1_ack), 0);

    // Stray response in IDLE produces nothing
    bus.mem_response = 1;
    tick();
    chk("idle_resp_ack", {30'd0, bus.p1_ack, bus.p0_ack}, 0);
    chk("idle_resp_busy", 32'(bus.busy), 0);
    bus.mem_response = 0;
    tick();

    // 3. Contention from a fresh reset (RR pointer = 0)
    #2 reset = 1;
    #2 reset = 0;
    exp_p0_rdata = 0; exp_p1_rdata = 0;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h100;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ct_gnt%0d", k), 32'(bus.grant_id), 32'(exp_gnt[k]));
      chk($sformatf("ct_addr%0d", k), bus.mem_addr, exp_gnt[k] ? 32'h200 : 32'h100);
      bus.mem_response = 1; bus.mem_read_val = 32'hA0 + 32'(k);
      tick();
      if (exp_gnt[k]) exp_p1_rdata = 32'hA0 + 32'(k);
      else            exp_p0_rdata = 32'hA0 + 32'(k);
      chk($sformatf("ct_ack%0d", k), {30'd0, bus.p1_ack, bus.p0_ack}, exp_gnt[k] ? 2 : 1);
      chk($sformatf("ct_p0d%0d", k), bus.p0_rdata, exp_p0_rdata);
      chk($sformatf("ct_p1d%0d", k), bus.p1_rdata, exp_p1_rdata);
      bus.mem_response = 0;
      tick();
    end
    bus.p0_req = 0; bus.p1_req = 0;
    tick();

    // 4. Timeout with TIMEOUT=8
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h20;
    tick();
    chk("to_en", 32'(bus.mem_read_en), 1);
    for (int i = 1; i < 8; i++) tick();
    chk("to_early_ack", 32'(bus.p0_ack), 0);
    chk("to_en_hold", 32'(bus.mem_read_en), 1);
    tick();
    chk("to_ack", 32'(bus.p0_ack), 1);
    chk("to_err", 32'(bus.p0_err), 1);
    chk("to_en_drop", 32'(bus.mem_read_en), 0);
    chk("to_rdata", bus.p0_rdata, exp_p0_rdata);
    bus.p0_req = 0;
    tick();
    chk("to_err_pulse", 32'(bus.p0_err), 0);
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h44;
    tick();
    bus.mem_response = 1; bus.mem_read_val = 32'h55AA55AA;
    tick();
    chk("to_next_ack", 32'(bus.p1_ack), 1);
    chk("to_next_err", 32'(bus.p1_err), 0);
    chk("to_next_rd", bus.p1_rdata, 32'h55AA55AA);
    bus.p1_req = 0; bus.mem_response = 0;
    tick();

    // 5. Slow release: response high for 5 sampled cycles
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h80; bus.p0_wdata = 32'h1;
    tick();
    bus.mem_response = 1;
    tick();
    chk("sr_ack", 32'(bus.p0_ack), 1);
    bus.p0_req = 0;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h90;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sr_hold%0d", i), {30'd0, bus.mem_write_en, bus.mem_read_en}, 0);
    end
    bus.mem_response = 0;
    tick();
    chk("sr_fall_en", {30'd0, bus.mem_write_en, bus.mem_read_en}, 0);
    tick();
    chk("sr_reissue", 32'(bus.mem_read_en), 1);
    chk("sr_gnt", 32'(bus.grant_id), 1);
    bus.mem_response = 1; bus.mem_read_val = 32'h77;
    tick();
    chk("sr_ack2", 32'(bus.p1_ack), 1);
    bus.p1_req = 0; bus.mem_response = 0;
    tick();

    // 6. Reset in ISSUE
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h30;
    tick();
    chk("rs_en", 32'(bus.mem_read_en), 1);
    #2 reset = 1;
    #1;
    chk("rs_async_en", 32'(bus.mem_read_en), 0);
    chk("rs_async_busy", 32'(bus.busy), 0);
    bus.mem_response = 1;
    tick();
    chk("rs_no_ack", 32'(bus.p0_ack), 0);
    reset = 0; bus.mem_response = 0;
    tick();
    chk("rs_reissue", 32'(bus.mem_read_en), 1);
    chk("rs_addr", bus.mem_addr, 32'h30);
    bus.mem_response = 1; bus.mem_read_val = 32'h600D600D;
    tick();
    chk("rs_ack", 32'(bus.p0_ack), 1);
    chk("rs_rdata", bus.p0_rdata, 32'h600D600D);
    bus.p0_req = 0; bus.mem_response = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
